// File: rtl/whack_a_mole_core.sv
// Whack-a-mole game engine: game FSM, LFSR mole spawner, per-slot lifetimes, BCD timer and score.
// Optional feature: define WAM_COMBO_EN for combo scoring (5th consecutive hit scores +2).
module whack_a_mole_core #(
    parameter int          GRID_W     = 3,
    parameter int          MOLES      = 2,
    parameter int          GAME_SECS  = 30,
    parameter int          LIFE_TICKS = 100,
    parameter int          LIFE_MIN   = 25,
    parameter int          LIFE_STEP  = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_50,
    input  logic                    tick_1,
    input  logic                    start,
    input  logic                    key_valid,
    input  logic [GRID_W-1:0]       key_row,
    input  logic [GRID_W-1:0]       key_col,
    output logic [MOLES-1:0]        mole_vld,
    output logic [MOLES*GRID_W-1:0] mole_row,
    output logic [MOLES*GRID_W-1:0] mole_col,
    output logic                    hit,
    output logic                    miss,
    output logic [1:0]              state,
    output logic [3:0]              time_shi,
    output logic [3:0]              time_ge,
    output logic [3:0]              score_shi,
    output logic [3:0]              score_ge
);

    localparam logic [1:0]  S_IDLE     = 2'b00;
    localparam logic [1:0]  S_PLAY     = 2'b01;
    localparam logic [1:0]  S_OVER     = 2'b10;
    localparam logic [15:0] SEED_NZ    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [3:0]  SECS_SHI   = 4'(GAME_SECS / 10);
    localparam logic [3:0]  SECS_GE    = 4'(GAME_SECS % 10);
    localparam logic [7:0]  LIFE_INIT  = 8'(LIFE_TICKS);
    localparam logic [7:0]  LIFE_FLOOR = 8'(LIFE_MIN);
    localparam logic [7:0]  LIFE_DEC   = 8'(LIFE_STEP);
    localparam logic [8:0]  LIFE_KNEE  = 9'(LIFE_MIN + LIFE_STEP);

    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [7:0]        life [MOLES];
    logic [7:0]        cur_life;
    logic              in_play;
    logic              do_tick;
    logic              do_key;
    logic              last_sec;
    logic [GRID_W-1:0] spawn_row;
    logic [GRID_W-1:0] spawn_col;
    logic [MOLES-1:0]  spawn_sel;
    logic [MOLES-1:0]  hit_sel;
    logic [MOLES-1:0]  expire;
    logic              spawn_clash;
    logic              spawn_go;
    logic              hit_any;
    logic              miss_any;
    logic              life_wrap;
    logic [7:0]        score_inc;
    logic [7:0]        score_sum;
    logic [3:0]        score_shi_nx;
    logic [3:0]        score_ge_nx;

`ifdef WAM_COMBO_EN
    logic [2:0] combo;
    logic       combo_bonus;

    assign combo_bonus = (combo == 3'd4);
    assign score_inc   = combo_bonus ? 8'd2 : 8'd1;
`else
    assign score_inc   = 8'd1;
`endif

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LIFE_TAPS_SEL() : 16'h0000);

    function automatic logic [15:0] LIFE_TAPS_SEL();
        return LFSR_TAPS;
    endfunction

    // All slot decisions look at occupancy as it stood at the start of the cycle.
    always_comb begin
        in_play     = (state == S_PLAY);
        do_tick     = in_play && tick_50;
        do_key      = in_play && key_valid;
        last_sec    = in_play && tick_1 && (time_shi == 4'd0) && (time_ge == 4'd1);
        spawn_row   = lfsr[GRID_W-1:0];
        spawn_col   = lfsr[2*GRID_W-1:GRID_W];
        spawn_clash = 1'b0;
        spawn_sel   = '0;
        hit_sel     = '0;
        expire      = '0;
        for (int i = MOLES - 1; i >= 0; i--) begin
            if (mole_vld[i] && (mole_row[i*GRID_W +: GRID_W] == spawn_row) &&
                (mole_col[i*GRID_W +: GRID_W] == spawn_col)) begin
                spawn_clash = 1'b1;
            end
            if (!mole_vld[i]) begin
                spawn_sel    = '0;
                spawn_sel[i] = 1'b1;
            end
            if (do_key && mole_vld[i] && (mole_row[i*GRID_W +: GRID_W] == key_row) &&
                (mole_col[i*GRID_W +: GRID_W] == key_col)) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
        hit_any = (hit_sel != '0);
        for (int i = 0; i < MOLES; i++) begin
            expire[i] = do_tick && mole_vld[i] && (life[i] == 8'd1) && !hit_sel[i];
        end
        miss_any     = (expire != '0);
        spawn_go     = do_tick && !spawn_clash && (spawn_sel != '0);
        score_sum    = (8'(score_shi) * 8'd10) + 8'(score_ge) + score_inc;
        if (score_sum > 8'd99) begin
            score_sum = 8'd99;
        end
        score_shi_nx = 4'(score_sum / 8'd10);
        score_ge_nx  = 4'(score_sum % 8'd10);
        life_wrap    = (score_shi_nx != score_shi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED_NZ;
            state     <= S_IDLE;
            mole_vld  <= '0;
            mole_row  <= '0;
            mole_col  <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            time_shi  <= 4'd0;
            time_ge   <= 4'd0;
            score_shi <= 4'd0;
            score_ge  <= 4'd0;
            cur_life  <= LIFE_INIT;
            for (int i = 0; i < MOLES; i++) begin
                life[i] <= 8'd0;
            end
`ifdef WAM_COMBO_EN
            combo     <= 3'd0;
`endif
        end else begin
            lfsr <= lfsr_next;
            hit  <= hit_any;
            miss <= miss_any;
            case (state)
                S_IDLE, S_OVER: begin
                    mole_vld <= '0;
                    if (start) begin
                        state     <= S_PLAY;
                        time_shi  <= SECS_SHI;
                        time_ge   <= SECS_GE;
                        score_shi <= 4'd0;
                        score_ge  <= 4'd0;
                        cur_life  <= LIFE_INIT;
`ifdef WAM_COMBO_EN
                        combo     <= 3'd0;
`endif
                    end
                end
                S_PLAY: begin
                    if (hit_any) begin
                        score_shi <= score_shi_nx;
                        score_ge  <= score_ge_nx;
                        if (life_wrap) begin
                            cur_life <= ({1'b0, cur_life} >= LIFE_KNEE) ? cur_life - LIFE_DEC
                                                                        : LIFE_FLOOR;
                        end
                    end
`ifdef WAM_COMBO_EN
                    if (miss_any) begin
                        combo <= 3'd0;
                    end else if (hit_any) begin
                        combo <= combo_bonus ? 3'd0 : combo + 3'd1;
                    end
`endif
                    for (int i = 0; i < MOLES; i++) begin
                        if (do_tick && mole_vld[i]) begin
                            life[i] <= life[i] - 8'd1;
                        end
                        if (expire[i] || hit_sel[i]) begin
                            mole_vld[i] <= 1'b0;
                        end
                        if (spawn_go && spawn_sel[i]) begin
                            mole_vld[i]                   <= 1'b1;
                            mole_row[i*GRID_W +: GRID_W] <= spawn_row;
                            mole_col[i*GRID_W +: GRID_W] <= spawn_col;
                            life[i]                       <= cur_life;
                        end
                    end
                    // The final second empties the board on the same edge that ends the game.
                    if (tick_1) begin
                        if (last_sec) begin
                            time_ge  <= 4'd0;
                            state    <= S_OVER;
                            mole_vld <= '0;
                        end else if (time_ge == 4'd0) begin
                            time_ge  <= 4'd9;
                            time_shi <= time_shi - 4'd1;
                        end else begin
                            time_ge  <= time_ge - 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    mole_vld <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_whack_a_mole_core.sv
// Directed self-checking bench for whack_a_mole_core (GRID_W=3, MOLES=2, LIFE_TICKS=4, LIFE_MIN=2, LIFE_STEP=1).
`timescale 1ns/1ps
module tb_whack_a_mole_core;

    localparam int GW = 3;
    localparam int NM = 2;
    localparam int GS = 30;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_50;
    logic             tick_1;
    logic             start;
    logic             key_valid;
    logic [GW-1:0]    key_row;
    logic [GW-1:0]    key_col;
    logic [NM-1:0]    mole_vld;
    logic [NM*GW-1:0] mole_row;
    logic [NM*GW-1:0] mole_col;
    logic             hit;
    logic             miss;
    logic [1:0]       state;
    logic [3:0]       time_shi;
    logic [3:0]       time_ge;
    logic [3:0]       score_shi;
    logic [3:0]       score_ge;

    int               errors = 0;
    int               checks = 0;
    logic [15:0]      m_lfsr;
    logic [GW-1:0]    c_row;
    logic [GW-1:0]    c_col;

    whack_a_mole_core #(
        .GRID_W(GW), .MOLES(NM), .GAME_SECS(GS), .LIFE_TICKS(4), .LIFE_MIN(2),
        .LIFE_STEP(1), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .tick_50(tick_50), .tick_1(tick_1), .start(start),
        .key_valid(key_valid), .key_row(key_row), .key_col(key_col),
        .mole_vld(mole_vld), .mole_row(mole_row), .mole_col(mole_col),
        .hit(hit), .miss(miss), .state(state), .time_shi(time_shi), .time_ge(time_ge),
        .score_shi(score_shi), .score_ge(score_ge)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR for x^16+x^14+x^13+x^11+1, used to predict spawn coordinates.
    always @(posedge clk) begin
        m_lfsr <= rst ? 16'hACE1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
    end

    task automatic do_reset();
        rst = 1'b1; tick_50 = 1'b0; tick_1 = 1'b0; start = 1'b0;
        key_valid = 1'b0; key_row = '0; key_col = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle strobe; c_row/c_col record the coordinates a tick_50 in this cycle would spawn.
    task automatic drive(input logic t50, input logic t1, input logic st, input logic kv,
                         input logic [GW-1:0] kr, input logic [GW-1:0] kc);
        @(negedge clk);
        c_row = m_lfsr[GW-1:0];
        c_col = m_lfsr[2*GW-1:GW];
        tick_50 = t50; tick_1 = t1; start = st; key_valid = kv; key_row = kr; key_col = kc;
        @(negedge clk);
        tick_50 = 1'b0; tick_1 = 1'b0; start = 1'b0; key_valid = 1'b0;
    endtask

    task automatic score_one();
        logic [GW-1:0] r;
        logic [GW-1:0] c;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r = c_row;
        c = c_col;
        drive(1'b0, 1'b0, 1'b0, 1'b1, r, c);
    endtask

    task automatic new_game();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b want 00", state); end
        checks++; if (mole_vld !== 2'b00 || mole_row !== '0 || mole_col !== '0) begin errors++; $display("[TB] FAIL reset_slots: got vld=%b row=%h col=%h want 0", mole_vld, mole_row, mole_col); end
        checks++; if (hit !== 1'b0 || miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got hit=%b miss=%b want 0", hit, miss); end
        checks++; if ({time_shi, time_ge, score_shi, score_ge} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd: got time=%h%h score=%h%h want 0000", time_shi, time_ge, score_shi, score_ge); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        checks++; if (state !== 2'b00 || hit !== 1'b0 || time_ge !== 4'd0) begin errors++; $display("[TB] FAIL idle_ignore: got state=%b hit=%b time_ge=%h want 00/0/0", state, hit, time_ge); end
    endtask

    task automatic test_countdown();
        int exp_t;
        new_game();
        checks++; if (state !== 2'b01 || {time_shi, time_ge} !== 8'h30) begin errors++; $display("[TB] FAIL start_load: got state=%b time=%h%h want 01 30", state, time_shi, time_ge); end
        for (int k = 1; k <= GS; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            exp_t = GS - k;
            checks++; if (time_shi !== 4'(exp_t / 10) || time_ge !== 4'(exp_t % 10)) begin errors++; $display("[TB] FAIL countdown_time k=%0d: got %h%h want %0d", k, time_shi, time_ge, exp_t); end
            checks++; if (state !== ((k == GS) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL countdown_state k=%0d: got %b", k, state); end
        end
        checks++; if ({score_shi, score_ge} !== 8'h00 || mole_vld !== 2'b00) begin errors++; $display("[TB] FAIL countdown_score: got score=%h%h vld=%b want 00 00", score_shi, score_ge, mole_vld); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (state !== 2'b10 || {time_shi, time_ge} !== 8'h00) begin errors++; $display("[TB] FAIL over_hold: got state=%b time=%h%h want 10 00", state, time_shi, time_ge); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++; if (state !== 2'b01 || {time_shi, time_ge} !== 8'h30) begin errors++; $display("[TB] FAIL restart: got state=%b time=%h%h want 01 30", state, time_shi, time_ge); end
    endtask

    task automatic test_spawn_expire();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        logic          exp1;
        new_game();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        checks++; if (mole_vld[0] !== 1'b1 || mole_row[GW-1:0] !== r0 || mole_col[GW-1:0] !== c0) begin errors++; $display("[TB] FAIL spawn0: got vld=%b row=%0d col=%0d want 1 %0d %0d", mole_vld, mole_row[GW-1:0], mole_col[GW-1:0], r0, c0); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        exp1 = !((c_row == r0) && (c_col == c0));
        checks++; if (mole_vld[1] !== exp1) begin errors++; $display("[TB] FAIL spawn1: got vld1=%b want %b", mole_vld[1], exp1); end
        if (exp1) begin
            checks++; if (mole_row[2*GW-1:GW] !== c_row || mole_col[2*GW-1:GW] !== c_col) begin errors++; $display("[TB] FAIL spawn1_xy: got %0d,%0d want %0d,%0d", mole_row[2*GW-1:GW], mole_col[2*GW-1:GW], c_row, c_col); end
        end
        for (int t = 3; t <= 4; t++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            checks++; if (mole_vld[0] !== 1'b1 || miss !== 1'b0) begin errors++; $display("[TB] FAIL alive tick=%0d: got vld0=%b miss=%b want 1 0", t, mole_vld[0], miss); end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++; if (mole_vld[0] !== 1'b0 || miss !== 1'b1) begin errors++; $display("[TB] FAIL expire: got vld0=%b miss=%b want 0 1", mole_vld[0], miss); end
        @(negedge clk);
        checks++; if (miss !== 1'b0) begin errors++; $display("[TB] FAIL miss_width: got miss=%b want 0", miss); end
    endtask

    task automatic test_hit();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        new_game();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        drive(1'b0, 1'b0, 1'b0, 1'b1, r0 ^ 3'd1, c0);
        checks++; if (hit !== 1'b0 || mole_vld !== 2'b01 || {score_shi, score_ge} !== 8'h00) begin errors++; $display("[TB] FAIL empty_key: got hit=%b vld=%b score=%h%h want 0 01 00", hit, mole_vld, score_shi, score_ge); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, r0, c0);
        checks++; if (hit !== 1'b1 || mole_vld !== 2'b00 || {score_shi, score_ge} !== 8'h01) begin errors++; $display("[TB] FAIL hit: got hit=%b vld=%b score=%h%h want 1 00 01", hit, mole_vld, score_shi, score_ge); end
        @(negedge clk);
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL hit_width: got hit=%b want 0", hit); end
    endtask

    task automatic test_back_to_back();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        new_game();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        @(negedge clk);
        key_valid = 1'b1; key_row = r0; key_col = c0 ^ 3'd2;
        @(negedge clk);
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first: got hit=%b want 0", hit); end
        key_col = c0;
        @(negedge clk);
        checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got hit=%b want 1", hit); end
        @(negedge clk);
        key_valid = 1'b0;
        checks++; if (hit !== 1'b0 || {score_shi, score_ge} !== 8'h01) begin errors++; $display("[TB] FAIL b2b_third: got hit=%b score=%h%h want 0 01", hit, score_shi, score_ge); end
    endtask

    task automatic test_hit_vs_expire();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        new_game();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, r0, c0);
        checks++; if (hit !== 1'b1 || miss !== 1'b0 || mole_vld[0] !== 1'b0 || {score_shi, score_ge} !== 8'h01) begin errors++; $display("[TB] FAIL hit_wins: got hit=%b miss=%b vld0=%b score=%h%h want 1 0 0 01", hit, miss, mole_vld[0], score_shi, score_ge); end
    endtask

    task automatic test_final_second();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        new_game();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        repeat (GS - 1) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (state !== 2'b01 || {time_shi, time_ge} !== 8'h01) begin errors++; $display("[TB] FAIL last_sec_pre: got state=%b time=%h%h want 01 01", state, time_shi, time_ge); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, r0, c0);
        checks++; if (hit !== 1'b1 || {score_shi, score_ge} !== 8'h01) begin errors++; $display("[TB] FAIL last_sec_hit: got hit=%b score=%h%h want 1 01", hit, score_shi, score_ge); end
        checks++; if (state !== 2'b10 || {time_shi, time_ge} !== 8'h00 || mole_vld !== 2'b00) begin errors++; $display("[TB] FAIL last_sec_over: got state=%b time=%h%h vld=%b want 10 00 00", state, time_shi, time_ge, mole_vld); end
    endtask

`ifdef WAM_COMBO_EN
    task automatic test_combo();
        logic [GW-1:0] r0;
        logic [GW-1:0] c0;
        logic          got1;
        logic [GW-1:0] r1;
        logic [GW-1:0] c1;
        new_game();
        repeat (5) score_one();
        checks++; if ({score_shi, score_ge} !== 8'h06) begin errors++; $display("[TB] FAIL combo5: got %h%h want 06", score_shi, score_ge); end
        new_game();
        repeat (4) score_one();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        r0 = c_row; c0 = c_col;
        got1 = 1'b0; r1 = '0; c1 = '0;
        for (int t = 2; t <= 5; t++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            if (!got1 && !((c_row == r0) && (c_col == c0))) begin
                got1 = 1'b1; r1 = c_row; c1 = c_col;
            end
        end
        checks++; if (miss !== 1'b1 || mole_vld[1] !== 1'b1) begin errors++; $display("[TB] FAIL combo_miss: got miss=%b vld1=%b want 1 1", miss, mole_vld[1]); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, r1, c1);
        checks++; if ({score_shi, score_ge} !== 8'h05) begin errors++; $display("[TB] FAIL combo_broken: got %h%h want 05", score_shi, score_ge); end
    endtask
`else
    task automatic test_life_step();
        int seen;
        new_game();
        repeat (10) score_one();
        checks++; if ({score_shi, score_ge} !== 8'h10) begin errors++; $display("[TB] FAIL score10: got %h%h want 10", score_shi, score_ge); end
        seen = 0;
        for (int t = 1; t <= 12 && seen == 0; t++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            if (miss === 1'b1) seen = t;
        end
        checks++; if (seen != 4) begin errors++; $display("[TB] FAIL life_after_wrap: got expiry tick %0d want 4", seen); end
    endtask

    task automatic test_saturate();
        int seen;
        new_game();
        repeat (99) score_one();
        checks++; if ({score_shi, score_ge} !== 8'h99) begin errors++; $display("[TB] FAIL score99: got %h%h want 99", score_shi, score_ge); end
        score_one();
        checks++; if (hit !== 1'b1 || {score_shi, score_ge} !== 8'h99) begin errors++; $display("[TB] FAIL saturate: got hit=%b score=%h%h want 1 99", hit, score_shi, score_ge); end
        seen = 0;
        for (int t = 1; t <= 12 && seen == 0; t++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            if (miss === 1'b1) seen = t;
        end
        checks++; if (seen != 3) begin errors++; $display("[TB] FAIL life_floor: got expiry tick %0d want 3", seen); end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_countdown();
        test_spawn_expire();
        test_hit();
        test_back_to_back();
        test_hit_vs_expire();
        test_final_second();
`ifdef WAM_COMBO_EN
        test_combo();
`else
        test_life_step();
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
